// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizing for the two-requester register-file arbiter.
package regfile_arb_pkg;
  localparam int NUM_REQ    = 2;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;
endpackage

// File: rtl/regfile_arbiter_if.sv
// Client-side bus of the register-file arbiter: packed per-requester commands and shared response.
interface regfile_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ-1:0]        re;
  logic [NUM_REQ*ADDR_W-1:0] waddr;
  logic [NUM_REQ*ADDR_W-1:0] raddr;
  logic [NUM_REQ*WIDTH-1:0]  wdata;
  logic [NUM_REQ-1:0]        done;
  logic [WIDTH-1:0]          rdata;

  modport master (output req, we, re, waddr, raddr, wdata, input done, rdata);
  modport slave  (input req, we, re, waddr, raddr, wdata, output done, rdata);
endinterface

// File: rtl/regfile_arbiter_picker.sv
// Combinational 2-way picker. Define REGFILE_ARB_RR_EN for round-robin ties;
// otherwise requester 0 wins every tie.
module arb_picker
  import regfile_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_last_grant,
  output logic               o_valid,
  output logic               o_grant
);
  always_comb begin
    o_valid = |i_req;
`ifdef REGFILE_ARB_RR_EN
    if (&i_req) o_grant = ~i_last_grant;
    else        o_grant = i_req[1];
`else
    o_grant = ~i_req[0];
`endif
  end

  logic w_unused;
`ifdef REGFILE_ARB_RR_EN
  assign w_unused = 1'b0;
`else
  assign w_unused = i_last_grant;
`endif
endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register-file write/read port between two requesters; each grant
// runs IDLE -> ACCESS -> RESP with registered rf_* outputs and a done pulse.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus,
  output logic              rf_write_enable,
  output logic              rf_read_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [ADDR_W-1:0] rf_read_addr,
  output logic [WIDTH-1:0]  rf_write_data,
  input  logic [WIDTH-1:0]  rf_read_data
);
  state_t             r_state, w_state_nxt;
  logic               r_grant, r_last_grant;
  logic [NUM_REQ-1:0] r_done;
  logic [WIDTH-1:0]   r_rdata;
  logic               w_valid, w_grant;

  arb_picker u_picker (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Addresses and write data keep their last values; only enables clear after ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_enable <= 1'b0;
      rf_read_enable  <= 1'b0;
      rf_write_addr   <= '0;
      rf_read_addr    <= '0;
      rf_write_data   <= '0;
      r_grant         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_done          <= '0;
      r_rdata         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            rf_write_enable <= bus.we[w_grant];
            rf_read_enable  <= bus.re[w_grant];
            rf_write_addr   <= bus.waddr[int'(w_grant)*ADDR_W +: ADDR_W];
            rf_read_addr    <= bus.raddr[int'(w_grant)*ADDR_W +: ADDR_W];
            rf_write_data   <= bus.wdata[int'(w_grant)*WIDTH +: WIDTH];
            r_grant         <= w_grant;
            r_last_grant    <= w_grant;
          end
        end
        ACCESS: begin
          if (rf_read_enable) r_rdata <= rf_read_data;
          rf_write_enable <= 1'b0;
          rf_read_enable  <= 1'b0;
          r_done[r_grant] <= 1'b1;
        end
        RESP:    r_done <= '0;
        default: r_done <= '0;
      endcase
    end
  end

  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x16 register file
// (read on negedge, write on posedge, outputs high-Z when read is disabled).
module tb_regfile_arbiter;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rf_write_enable, rf_read_enable;
  logic [ADDR_W-1:0] rf_write_addr, rf_read_addr;
  logic [WIDTH-1:0]  rf_write_data;
  wire  [WIDTH-1:0]  rf_read_data;

  logic [WIDTH-1:0]  mem [8] = '{default: '0};
  logic [WIDTH-1:0]  rd_q = '0;

  int errors = 0;
  int checks = 0;

  regfile_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regfile_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .rf_write_enable (rf_write_enable),
    .rf_read_enable  (rf_read_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_read_addr    (rf_read_addr),
    .rf_write_data   (rf_write_data),
    .rf_read_data    (rf_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_write_enable) mem[rf_write_addr] <= rf_write_data;
  always @(negedge clk) if (rf_read_enable) rd_q <= mem[rf_read_addr];
  assign rf_read_data = rf_read_enable ? rd_q : 'z;

  typedef struct {
    logic [1:0]  req, we, re;
    logic [5:0]  waddr, raddr;
    logic [31:0] wdata;
    logic        exp_we, exp_re;
    logic [2:0]  exp_waddr, exp_raddr;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_done;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] re,
                       input logic [5:0] wa, input logic [5:0] ra, input logic [31:0] wd);
    bus.req = req; bus.we = we; bus.re = re;
    bus.waddr = wa; bus.raddr = ra; bus.wdata = wd;
  endtask

  // Drive in IDLE, check rf_* during ACCESS, check done/rdata during RESP, drop req.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    drive(v.req, v.we, v.re, v.waddr, v.raddr, v.wdata);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_access_we", idx), 32'(rf_write_enable), 32'(v.exp_we));
    chk($sformatf("v%0d_access_re", idx), 32'(rf_read_enable), 32'(v.exp_re));
    chk($sformatf("v%0d_waddr", idx), 32'(rf_write_addr), 32'(v.exp_waddr));
    chk($sformatf("v%0d_raddr", idx), 32'(rf_read_addr), 32'(v.exp_raddr));
    chk($sformatf("v%0d_wdata", idx), 32'(rf_write_data), 32'(v.exp_wdata));
    chk($sformatf("v%0d_access_done", idx), 32'(bus.done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), 32'(bus.done), 32'(v.exp_done));
    chk($sformatf("v%0d_rdata", idx), 32'(bus.rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d_resp_en", idx), 32'({rf_write_enable, rf_read_enable}), 32'd0);
    chk($sformatf("v%0d_hold_waddr", idx), 32'(rf_write_addr), 32'(v.exp_waddr));
    @(posedge clk);
    #1 drive(2'b00, 2'b00, 2'b00, '0, '0, '0);
  endtask

  initial begin
    logic [1:0]  exp_order [4];
    logic [15:0] exp_rd    [4];

    vecs[0] = '{2'b01, 2'b01, 2'b00, 6'o07, 6'o00, {16'h0000, 16'h78da}, 1'b1, 1'b0, 3'd7, 3'd0, 16'h78da, 2'b01, 16'h0000};
    vecs[1] = '{2'b01, 2'b00, 2'b01, 6'o00, 6'o07, 32'h0,                1'b0, 1'b1, 3'd0, 3'd7, 16'h0000, 2'b01, 16'h78da};
    vecs[2] = '{2'b10, 2'b10, 2'b00, 6'o20, 6'o00, {16'h123f, 16'h0000}, 1'b1, 1'b0, 3'd2, 3'd0, 16'h123f, 2'b10, 16'h78da};
    vecs[3] = '{2'b10, 2'b10, 2'b10, 6'o20, 6'o20, {16'h4532, 16'h0000}, 1'b1, 1'b1, 3'd2, 3'd2, 16'h4532, 2'b10, 16'h123f};
    vecs[4] = '{2'b01, 2'b00, 2'b01, 6'o00, 6'o02, 32'h0,                1'b0, 1'b1, 3'd0, 3'd2, 16'h0000, 2'b01, 16'h4532};
    vecs[5] = '{2'b10, 2'b00, 2'b00, 6'o50, 6'o60, {16'hdead, 16'h0000}, 1'b0, 1'b0, 3'd5, 3'd6, 16'hdead, 2'b10, 16'h4532};
    vecs[6] = '{2'b01, 2'b00, 2'b01, 6'o00, 6'o07, 32'h0,                1'b0, 1'b1, 3'd0, 3'd7, 16'h0000, 2'b01, 16'h78da};
    vecs[7] = '{2'b01, 2'b00, 2'b01, 6'o00, 6'o05, 32'h0,                1'b0, 1'b1, 3'd0, 3'd5, 16'h0000, 2'b01, 16'h0000};

`ifdef REGFILE_ARB_RR_EN
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd    = '{16'h78da, 16'h4532, 16'h78da, 16'h4532};
`else
    exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_rd    = '{16'h78da, 16'h78da, 16'h78da, 16'h78da};
`endif

    // Reset held with both requesters asserting.
    drive(2'b11, 2'b00, 2'b00, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_rf", 32'({rf_write_enable, rf_read_enable, rf_write_addr, rf_read_addr, rf_write_data}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", 32'(bus.done), 32'(2'b01));
    @(posedge clk);
    #1 drive(2'b00, 2'b00, 2'b00, '0, '0, '0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Contention: both requesters read continuously for four grants.
    drive(2'b11, 2'b00, 2'b11, '0, 6'o27, '0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("contend%0d_done", i), 32'(bus.done), 32'(exp_order[i]));
      chk($sformatf("contend%0d_rdata", i), 32'(bus.rdata), 32'(exp_rd[i]));
      @(posedge clk);
    end
    #1 drive(2'b00, 2'b00, 2'b00, '0, '0, '0);

    // Reset arrives mid-ACCESS of a write; the write and its done must vanish.
    drive(2'b01, 2'b01, 2'b00, 6'o05, '0, {16'h0000, 16'hbeef});
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_we", 32'(rf_write_enable), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_we", 32'(rf_write_enable), 32'd0);
    chk("abort_waddr", 32'(rf_write_addr), 32'd0);
    chk("abort_rdata", 32'(bus.rdata), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_vec(6);
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-requester controller that shares the 8x16 register file's single write port and single read port.
- Sequences each granted transaction through one register-file access cycle.
- Captures the read data and returns it with a one-cycle done pulse.
- Sits between two client datapaths and the register file instance (write on posedge, read on negedge).

Parameters:
WIDTH, 16, data width of register file and client buses
ADDR_W, 3, register address width (8 registers)

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
req  in  2  per-requester request; bit i = requester i
we  in  2  per-requester write request
re  in  2  per-requester read request
waddr  in  2*ADDR_W  packed write addresses, requester i at [i*ADDR_W +: ADDR_W]
raddr  in  2*ADDR_W  packed read addresses, same packing
wdata  in  2*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
done  out  2  one-cycle completion pulse per requester
rdata  out  WIDTH  read result, valid while the corresponding done bit is high
rf_write_enable  out  1  to register file write_enable
rf_read_enable  out  1  to register file read_enable
rf_write_addr  out  ADDR_W  to register file write_addr
rf_read_addr  out  ADDR_W  to register file read_addr
rf_write_data  out  WIDTH  to register file write_data
rf_read_data  in  WIDTH  from register file read_data (high-Z when read disabled)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- Reset (rst=0, async):
  - state=IDLE; done=0; rdata=0.
  - All rf_* outputs = 0.
  - last_grant=1, so requester 0 has priority first.
- IDLE:
  - If any req bit is high at the posedge, pick a winner (see Optional Feature).
  - Latch the winner's we/re/addresses/wdata into the rf_* registers, record the grant index, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - rf_* outputs are stable for the whole cycle.
  - Register file performs the read on the mid-cycle negedge and the write on the closing posedge.
  - At the closing posedge:
    - If re was latched, capture rf_read_data into rdata; otherwise rdata holds its previous value.
    - Clear rf_write_enable and rf_read_enable.
    - Set done[grant]=1, go to RESP.
- RESP (1 cycle): done[grant] is high. At the closing posedge clear done and go to IDLE; no arbitration happens in RESP.
- Latency and throughput:
  - req sampled in IDLE -> done exactly 2 cycles later.
  - Sustained throughput is 1 transaction per 3 cycles.
- Requester rule:
  - Hold req and all command fields stable from assertion until done is seen.
  - Deassert req at the posedge ending the done cycle.
  - If req is still high in the following IDLE, it is treated as a new transaction.
- req with we=re=0: still granted and handshaked; rf enables stay 0 and rdata is unchanged.
- we=re=1 with the same address in one transaction: the read returns the OLD contents, because the negedge read precedes the posedge write. The new value is visible to the next transaction.
- rf_* addresses and data hold their last values after ACCESS; only the enables clear.
- Reset mid-transaction (any state): immediate return to the reset values above.
  - A pending write is dropped if rst falls before the ACCESS closing posedge.
  - No done pulse is generated for the aborted transaction.
- Simultaneous req=2'b11: exactly one grant; the loser stays pending and is served next.

Optional Feature:
- Macro: REGFILE_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie the winner is the requester != last_grant. last_grant updates on every grant.
- Undefined: fixed priority, requester 0 always wins a tie. last_grant is still maintained but ignored. Requester 1 can starve under continuous requester-0 traffic.

Decomposition:
- Package regfile_arb_pkg holds:
  - FSM state enum (IDLE, ACCESS, RESP).
  - NUM_REQ=2.
  - Default WIDTH/ADDR_W constants.
- One sub-module, arb_picker: combinational 2-way picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: valid, grant index.
  - Contains the REGFILE_ARB_RR_EN selection.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with req=2'b11 -> done=0, rdata=0, all rf_* =0, state IDLE; release, and the first grant goes to requester 0.
2. Write then read: req0 writes 16'h78da to addr 7; after done, req0 reads addr 7 -> rdata=16'h78da with done[0] exactly 2 cycles after req is sampled.
3. Same-address read+write: addr 2 holds 16'h123f; req1 we=re=1, wdata=16'h4532, addr 2 -> rdata=16'h123f; a subsequent read of addr 2 -> 16'h4532.
4. Contention with REGFILE_ARB_RR_EN defined: req=2'b11 held for 4 transactions -> done order 0,1,0,1. Without the macro -> 0,0,0,0 while req0 stays high.
5. Reset during ACCESS of a write of 16'hbeef to addr 5 -> no done pulse; a later read of addr 5 returns the register file's reset value 16'h0000.
6. No-op request (we=re=0) from req1 -> done[1] pulses, rf enables stay 0, rdata unchanged from the previous value.
